// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3, one bit per clock) with a
// start/busy/done handshake; feeds the per-digit 7-segment decoders.
module bin2bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     adj_s;
    logic [BW-1:0]     shifted_s;
    logic              ovf_next_s;

    // Adds 3 to every digit >= 5; digits are adjusted independently.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] acc);
        logic [BW-1:0] r;
        r = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble iteration; a bit leaving the top digit marks overflow.
    always_comb begin
        adj_s      = add3_digits(acc_q);
        shifted_s  = {adj_s[BW-2:0], bin_q[WIDTH-1]};
        ovf_next_s = ovf_acc_q | adj_s[BW-1];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    bin_d     = bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                acc_d     = shifted_s;
                ovf_acc_d = ovf_next_s;
                cnt_d     = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = shifted_s;
                    ovf_d   = ovf_next_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial in three configurations: (8,3), (8,2), (14,5).
module tb_bin2bcd_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s;
    logic [1:0]  sel_s;
    logic [13:0] bin_s;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;

    logic        busy_s, done_s, ovf_s;
    logic [19:0] bcd_s;

    bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_s && sel_s == 2'd0), .bin_in(bin_s[7:0]),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a));

    bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_s && sel_s == 2'd1), .bin_in(bin_s[7:0]),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b));

    bin2bcd_serial #(.WIDTH(14), .DIGITS(5)) dut_c (
        .clk(clk), .rst(rst), .start(start_s && sel_s == 2'd2), .bin_in(bin_s),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c));

    always_comb begin
        busy_s = busy_a; done_s = done_a; ovf_s = ovf_a; bcd_s = {8'd0, bcd_a};
        case (sel_s)
            2'd1: begin busy_s = busy_b; done_s = done_b; ovf_s = ovf_b; bcd_s = {12'd0, bcd_b}; end
            2'd2: begin busy_s = busy_c; done_s = done_c; ovf_s = ovf_c; bcd_s = bcd_c; end
            default: ;
        endcase
    end

    typedef struct {
        int          sel;
        int          bin;
        logic [19:0] exp_bcd;
        logic        exp_ovf;
        int          lat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] last_bcd [3];
    vec_t        vecs [12];

    function automatic vec_t mk(int sel, int bin, logic [19:0] b, logic o, int lat);
        vec_t v;
        v.sel = sel; v.bin = bin; v.exp_bcd = b; v.exp_ovf = o; v.lat = lat;
        return v;
    endfunction

    // Arithmetic reference: low 'digits' decimal digits, overflow if anything remains.
    function automatic logic [20:0] ref_bcd(int value, int digits);
        logic [19:0] r;
        int v;
        r = 20'd0;
        v = value;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {(v != 0), r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done after the accepting edge, checking busy and held outputs.
    task automatic wait_done(input string name, input int lat);
        int   n;
        logic bad;
        n = 0;
        bad = 1'b0;
        while (done_s !== 1'b1 && n < 40) begin
            if (busy_s !== 1'b1 || bcd_s !== last_bcd[sel_s]) bad = 1'b1;
            step();
            n++;
        end
        chk({name, "_busy_hold"}, {31'd0, bad}, 32'd0);
        chk({name, "_latency"}, n, lat);
        chk({name, "_busy_at_done"}, {31'd0, busy_s}, 32'd0);
    endtask

    task automatic run_conv(input string name, input int sel, input int bin,
                            input logic [19:0] exp_bcd, input logic exp_ovf, input int lat);
        sel_s = 2'(sel);
        bin_s = 14'(bin);
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        bin_s = ~bin_s;
        wait_done(name, lat);
        chk({name, "_bcd"}, {12'd0, bcd_s}, {12'd0, exp_bcd});
        chk({name, "_ovf"}, {31'd0, ovf_s}, {31'd0, exp_ovf});
        last_bcd[sel] = exp_bcd;
        step();
        chk({name, "_done_pulse"}, {31'd0, done_s}, 32'd0);
    endtask

    task automatic no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done_s !== 1'b0) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [20:0] r;
        rst = 1'b1; start_s = 1'b0; sel_s = 2'd0; bin_s = 14'd0;
        for (int i = 0; i < 3; i++) last_bcd[i] = 20'd0;

        vecs[0]  = mk(0, 0,     20'h00000, 1'b0, 8);
        vecs[1]  = mk(0, 9,     20'h00009, 1'b0, 8);
        vecs[2]  = mk(0, 10,    20'h00010, 1'b0, 8);
        vecs[3]  = mk(0, 99,    20'h00099, 1'b0, 8);
        vecs[4]  = mk(0, 128,   20'h00128, 1'b0, 8);
        vecs[5]  = mk(0, 255,   20'h00255, 1'b0, 8);
        vecs[6]  = mk(1, 99,    20'h00099, 1'b0, 8);
        vecs[7]  = mk(1, 100,   20'h00000, 1'b1, 8);
        vecs[8]  = mk(1, 255,   20'h00055, 1'b1, 8);
        vecs[9]  = mk(1, 7,     20'h00007, 1'b0, 8);
        vecs[10] = mk(2, 9999,  20'h09999, 1'b0, 14);
        vecs[11] = mk(2, 16383, 20'h16383, 1'b0, 14);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outputs", {9'd0, busy_a, done_a, ovf_a, 8'd0, bcd_a}, 32'd0);
        end

        foreach (vecs[i])
            run_conv($sformatf("vec%0d", i), vecs[i].sel, vecs[i].bin,
                     vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].lat);

        // Back-to-back with start held high; bin_in changes after each accept.
        sel_s = 2'd0; bin_s = 14'd37; start_s = 1'b1;
        step();
        bin_s = 14'd200;
        wait_done("b2b_first", 8);
        chk("b2b_first_bcd", {12'd0, bcd_s}, 32'h037);
        last_bcd[0] = 20'h00037;
        step();
        bin_s = 14'd5;
        wait_done("b2b_second", 8);
        chk("b2b_second_bcd", {12'd0, bcd_s}, 32'h200);
        last_bcd[0] = 20'h00200;
        start_s = 1'b0;
        step();
        chk("b2b_done_drop", {31'd0, done_s}, 32'd0);

        // A start pulse while busy must be ignored.
        bin_s = 14'd55; start_s = 1'b1;
        step();
        start_s = 1'b0;
        repeat (3) step();
        bin_s = 14'd99; start_s = 1'b1;
        step();
        start_s = 1'b0;
        wait_done("busy_start", 4);
        chk("busy_start_bcd", {12'd0, bcd_s}, 32'h055);
        last_bcd[0] = 20'h00055;
        no_done("busy_start_no_extra", 14);

        // Reset in the middle of a conversion.
        bin_s = 14'd255; start_s = 1'b1;
        step();
        start_s = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", {9'd0, busy_a, done_a, ovf_a, 8'd0, bcd_a}, 32'd0);
        for (int i = 0; i < 3; i++) last_bcd[i] = 20'd0;
        no_done("midrst_no_done", 12);
        run_conv("after_rst", 0, 42, 20'h00042, 1'b0, 8);

        // Exhaustive sweep against the arithmetic model.
        for (int v = 0; v < 256; v++) begin
            r = ref_bcd(v, 3);
            run_conv($sformatf("sweep%0d", v), 0, v, r[19:0], r[20], 8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
